// File: rtl/latch_array_ctrl_if.sv
// rtl/latch_array_ctrl_if.sv - requester and latch-array bus bundle for latch_array_ctrl
//
// Purpose: groups the two requester ports and the decoder/array port into one bundle.
//   req_x, we_x, addr_x, wdata_x : requester x request (x = a, b)
//   ack_x, rsp_valid_x           : grant pulse and completion pulse for requester x
//   rdata                        : shared registered read data
//   arr_select, arr_adr          : address decoder select and row address
//   arr_we, arr_wdata, arr_rdata : array write enable, write data, read data
// Modports: slave = controller side, master = requesters plus array side.
interface latch_array_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              req_a;
  logic              req_b;
  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] wdata_b;
  logic              ack_a;
  logic              ack_b;
  logic              rsp_valid_a;
  logic              rsp_valid_b;
  logic [DATA_W-1:0] rdata;
  logic              arr_select;
  logic [ADDR_W-1:0] arr_adr;
  logic              arr_we;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, arr_rdata,
    output ack_a, ack_b, rsp_valid_a, rsp_valid_b, rdata,
    output arr_select, arr_adr, arr_we, arr_wdata
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, arr_rdata,
    input  ack_a, ack_b, rsp_valid_a, rsp_valid_b, rdata,
    input  arr_select, arr_adr, arr_we, arr_wdata
  );
endinterface

// File: rtl/latch_array_ctrl.sv
// rtl/latch_array_ctrl.sv - two-port round-robin access controller for the 8-word latch array
//
// Purpose: arbitrates read/write requests from requesters A and B and sequences the
// decoder select, address and array write enable through setup/access/recover.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : latch_array_ctrl_if.slave (requester A/B ports, shared rdata, array port)
module latch_array_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input logic                clk,
  input logic                rst_n,
  latch_array_ctrl_if.slave  bus
);

  // All outputs are registered, so each state computes what the array port shows
  // in the following cycle: the edge leaving IDLE loads the address/data (ack
  // cycle), SETUP raises arr_we, ACCESS raises arr_select, RECOVER drops both
  // and issues the response.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

  state_t            state;
  logic              rr;       // 1 = requester B wins the next tie
  logic              gnt_b;    // owner of the access in flight
  logic              we_r;
  logic              ack_a_q;
  logic              ack_b_q;
  logic              rsp_a_q;
  logic              rsp_b_q;
  logic              sel_q;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic any_req;
  logic pick_b;

  always_comb begin
    any_req = bus.req_a || bus.req_b;
    pick_b  = bus.req_b && (!bus.req_a || rr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr      <= 1'b0;
      gnt_b   <= 1'b0;
      we_r    <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      rsp_a_q <= 1'b0;
      rsp_b_q <= 1'b0;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      rsp_a_q <= 1'b0;
      rsp_b_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            ack_a_q <= !pick_b;
            ack_b_q <= pick_b;
            gnt_b   <= pick_b;
            rr      <= !pick_b;
            we_r    <= pick_b ? bus.we_b : bus.we_a;
            // Address and data move only here, while arr_select is low.
            adr_q   <= pick_b ? bus.addr_b : bus.addr_a;
            wdata_q <= pick_b ? bus.wdata_b : bus.wdata_a;
            state   <= SETUP;
          end
        end
        SETUP: begin
          we_q  <= we_r;
          state <= ACCESS;
        end
        ACCESS: begin
          sel_q <= 1'b1;
          state <= RECOVER;
        end
        RECOVER: begin
          // This edge ends the select-high cycle, so arr_rdata is sampled here.
          sel_q   <= 1'b0;
          we_q    <= 1'b0;
          rsp_a_q <= !gnt_b;
          rsp_b_q <= gnt_b;
          if (!we_r) begin
            rdata_q <= bus.arr_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack_a       = ack_a_q;
  assign bus.ack_b       = ack_b_q;
  assign bus.rsp_valid_a = rsp_a_q;
  assign bus.rsp_valid_b = rsp_b_q;
  assign bus.rdata       = rdata_q;
  assign bus.arr_select  = sel_q;
  assign bus.arr_adr     = adr_q;
  assign bus.arr_we      = we_q;
  assign bus.arr_wdata   = wdata_q;

endmodule

// File: tb/tb_latch_array_ctrl.sv
// tb/tb_latch_array_ctrl.sv - self-checking bench for latch_array_ctrl
module tb_latch_array_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  latch_array_ctrl_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  latch_array_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Latch array environment: combinational read, write while selected.
  logic [7:0] arr_mem [8] = '{default: 8'h00};
  assign bus.arr_rdata = arr_mem[bus.arr_adr];
  always @(posedge clk) begin
    if (bus.arr_select && bus.arr_we) arr_mem[bus.arr_adr] <= bus.arr_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: k counts cycles since the ack of the access in flight
  // (-1 = none). Ack at k=0, select at k=2, response at k=3, next grant possible
  // on the edge leaving k=3.
  int         k;
  logic       m_id;
  logic       m_rr;
  logic       m_we;
  logic [2:0] m_adr;
  logic [7:0] m_wd;
  logic [7:0] m_rdata;
  logic [7:0] m_mem [8] = '{default: 8'h00};
  wire        m_pick_b = (bus.req_a && bus.req_b) ? m_rr : bus.req_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= -1; m_id <= 1'b0; m_rr <= 1'b0; m_we <= 1'b0;
      m_adr <= 3'd0; m_wd <= 8'd0; m_rdata <= 8'd0;
    end else begin
      if (k == 2 && m_we)  m_mem[m_adr] <= m_wd;
      if (k == 2 && !m_we) m_rdata <= m_mem[m_adr];
      if (k == -1 || k == 3) begin
        if (bus.req_a || bus.req_b) begin
          k     <= 0;
          m_id  <= m_pick_b;
          m_rr  <= !m_pick_b;
          m_we  <= m_pick_b ? bus.we_b : bus.we_a;
          m_adr <= m_pick_b ? bus.addr_b : bus.addr_a;
          m_wd  <= m_pick_b ? bus.wdata_b : bus.wdata_a;
        end else begin
          k <= -1;
        end
      end else begin
        k <= k + 1;
      end
    end
  end

  logic prev_sel = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("ack_a",       bus.ack_a,       32'(k == 0 && !m_id));
      chk("ack_b",       bus.ack_b,       32'(k == 0 && m_id));
      chk("arr_select",  bus.arr_select,  32'(k == 2));
      chk("arr_we",      bus.arr_we,      32'(m_we && (k == 1 || k == 2)));
      chk("rsp_valid_a", bus.rsp_valid_a, 32'(k == 3 && !m_id));
      chk("rsp_valid_b", bus.rsp_valid_b, 32'(k == 3 && m_id));
      chk("arr_adr",     bus.arr_adr,     m_adr);
      chk("arr_wdata",   bus.arr_wdata,   m_wd);
      chk("rdata",       bus.rdata,       m_rdata);
      chk("select_back_to_back", 32'(bus.arr_select && prev_sel), 0);
    end
    prev_sel <= bus.arr_select;
  end

  task automatic set_a(input logic r, input logic w, input logic [2:0] a, input logic [7:0] d);
    bus.req_a = r; bus.we_a = w; bus.addr_a = a; bus.wdata_a = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [2:0] a, input logic [7:0] d);
    bus.req_b = r; bus.we_b = w; bus.addr_b = a; bus.wdata_b = d;
  endtask

  // Raise a request, hold it until its ack is seen, return the ack cycle.
  task automatic issue(input logic is_b, input logic w, input logic [2:0] a,
                       input logic [7:0] d, output int ack_cyc);
    logic got;
    got = 1'b0;
    ack_cyc = -1;
    if (is_b) set_b(1'b1, w, a, d); else set_a(1'b1, w, a, d);
    for (int i = 0; i < 24 && !got; i++) begin
      @(posedge clk); #1;
      if (is_b ? bus.ack_b : bus.ack_a) begin
        got = 1'b1;
        ack_cyc = cyc;
      end
    end
    if (is_b) bus.req_b = 1'b0; else bus.req_a = 1'b0;
    if (!got) chk("ack_timeout", 0, 1);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  int t;
  int t_prev;
  int ack_who [4];
  int ack_at [4];
  int n_acks;

  initial begin
    rst_n = 1'b0;
    set_a(1'b0, 1'b0, 3'd0, 8'd0);
    set_b(1'b0, 1'b0, 3'd0, 8'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Reset in the middle of ACCESS of a write to address 5.
    issue(1'b0, 1'b1, 3'd5, 8'h3C, t);
    step; step;
    chk("rst_pre_select", bus.arr_select, 1);
    chk("rst_pre_we", bus.arr_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_select", bus.arr_select, 0);
    chk("rst_we", bus.arr_we, 0);
    chk("rst_outputs", {bus.ack_a, bus.ack_b, bus.rsp_valid_a, bus.rsp_valid_b,
                        bus.arr_adr, bus.arr_wdata, bus.rdata}, 0);
    step;
    chk("rst_no_rsp_a", bus.rsp_valid_a, 0);
    step;
    chk("rst_no_rsp_a_2", bus.rsp_valid_a, 0);
    #2 rst_n = 1'b1;
    step;
    chk("rst_idle_no_ack", bus.ack_a, 0);
    issue(1'b0, 1'b0, 3'd5, 8'd0, t);
    step; step; step;
    chk("rst_clean_rsp_a", bus.rsp_valid_a, 1);
    chk("rst_aborted_write", bus.rdata, 8'h00);

    // Write 0xA5 to address 3, then read it back.
    issue(1'b0, 1'b1, 3'd3, 8'hA5, t);
    step; step;
    chk("wr_select", bus.arr_select, 1);
    chk("wr_adr", bus.arr_adr, 3);
    step;
    issue(1'b0, 1'b0, 3'd3, 8'd0, t_prev);
    chk("rd_ack_after_wr", t_prev - t, 4);
    step; step;
    chk("rd_select", bus.arr_select, 1);
    chk("rd_adr", bus.arr_adr, 3);
    step;
    chk("rd_rsp_valid_a", bus.rsp_valid_a, 1);
    chk("rd_rdata", bus.rdata, 8'hA5);

    // Both requesters held from reset: A writes 0, B writes 7.
    #2 rst_n = 1'b0;
    step;
    set_a(1'b1, 1'b1, 3'd0, 8'h11);
    set_b(1'b1, 1'b1, 3'd7, 8'h77);
    #2 rst_n = 1'b1;
    n_acks = 0;
    for (int i = 0; i < 40 && n_acks < 4; i++) begin
      step;
      if (bus.ack_a || bus.ack_b) begin
        ack_who[n_acks] = bus.ack_b ? 1 : 0;
        ack_at[n_acks]  = cyc;
        chk("arb_adr", bus.arr_adr, bus.ack_b ? 7 : 0);
        n_acks++;
      end
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    chk("arb_ack_count", n_acks, 4);
    chk("arb_order", {ack_who[0][0], ack_who[1][0], ack_who[2][0], ack_who[3][0]}, 4'b0101);
    for (int i = 1; i < 4; i++) chk("arb_spacing", ack_at[i] - ack_at[i-1], 4);
    step; step; step;

    // Pre-write 8*addr via A, then B reads 0..7 back-to-back.
    for (int i = 0; i < 8; i++) issue(1'b0, 1'b1, 3'(i), 8'(8 * i), t);
    step; step; step;
    for (int i = 0; i < 8; i++) begin
      t_prev = t;
      issue(1'b1, 1'b0, 3'(i), 8'd0, t);
      if (i > 0) begin
        chk("b2b_ack_spacing", t - t_prev, 4);
        chk("b2b_rdata", bus.rdata, 8 * (i - 1));
      end
    end
    step; step; step;
    chk("b2b_last_rsp_b", bus.rsp_valid_b, 1);
    chk("b2b_last_rdata", bus.rdata, 8'd56);

    // Address change right after ack must not disturb the access in flight.
    issue(1'b0, 1'b0, 3'd2, 8'd0, t);
    step;
    set_a(1'b1, 1'b0, 3'd6, 8'd0);
    for (int i = 1; i <= 3; i++) begin
      chk("stab_adr", bus.arr_adr, 2);
      chk("stab_no_ack", bus.ack_a, 0);
      if (i < 3) step;
    end
    step;
    chk("stab_ack_next_idle", bus.ack_a, 1);
    chk("stab_new_adr", bus.arr_adr, 6);
    bus.req_a = 1'b0;
    step; step; step;

    // B arrives during the SETUP of an A access; A re-requests too.
    issue(1'b0, 1'b1, 3'd1, 8'h5A, t);
    step;
    set_b(1'b1, 1'b0, 3'd1, 8'd0);
    set_a(1'b1, 1'b0, 3'd4, 8'd0);
    for (int i = 1; i <= 3; i++) begin
      chk("late_no_ack_b", bus.ack_b, 0);
      if (i < 3) step;
    end
    step;
    chk("late_ack_b", bus.ack_b, 1);
    chk("late_not_a", bus.ack_a, 0);
    bus.req_b = 1'b0;
    step; step; step; step;
    chk("late_then_a", bus.ack_a, 1);
    bus.req_a = 1'b0;
    step; step; step; step;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
